cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Arbitrates between the I-cache and D-cache fill state machines for the single pipelined main-memory read port. For each granted miss it generates all eight word addresses of the 16-byte block and routes each returned word to the winning cache. It sits directly downstream of both fill FSMs and directly upstream of the memory module. Each fill FSM then only counts returned valids and writes the data and tag arrays.

## Interface
Parameters:
- WORDS_PER_BLOCK, 8: words per cache block; must be a power of two; byte offset width is log2(WORDS_PER_BLOCK)+1.
- ADDR_W, 16: byte address width; data word is 16 bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- icache_req  in  1  I-cache fill FSM busy; level, held until icache_done.
- icache_addr  in  ADDR_W  I-cache miss address; latched at grant.
- dcache_req  in  1  D-cache fill FSM busy; level, held until dcache_done.
- dcache_addr  in  ADDR_W  D-cache miss address; latched at grant.
- mem_en  out  1  memory read enable, one address per cycle.
- mem_addr  out  ADDR_W  memory read byte address.
- mem_data  in  16  memory read data.
- mem_data_valid  in  1  mem_data valid; fixed latency after mem_en, in issue order.
- fill_data  out  16  mem_data passed through combinationally.
- icache_data_valid / dcache_data_valid  out  1  each: mem_data_valid steered to the granted cache.
- icache_grant / dcache_grant  out  1  each: a fill owned by that cache is in progress.
- icache_done / dcache_done  out  1  each: one-cycle pulse on the final word of that cache's fill.

## Operation
- States: IDLE, ISSUE, DRAIN. Registers: state, owner (1 = D-cache), base[ADDR_W-1:0], issue_cnt, ret_cnt (log2(WORDS_PER_BLOCK) bits each), last_owner (round-robin build only).
- IDLE:
  - If no request is asserted, stay in IDLE.
  - Otherwise pick an owner. Latch base = owner address with the low 4 bits cleared. Clear both counters. Go to ISSUE.
- ISSUE:
  - Drive mem_en=1 and mem_addr = base + 2*issue_cnt. Word order is ascending from offset 0; critical word first is not supported.
  - issue_cnt increments each cycle.
  - In the cycle issue_cnt = WORDS_PER_BLOCK-1, go to DRAIN.
- DRAIN: mem_en=0; wait for returns.
- Returns:
  - In ISSUE or DRAIN, each mem_data_valid increments ret_cnt and asserts the owner's data_valid only.
  - When mem_data_valid coincides with ret_cnt = WORDS_PER_BLOCK-1, pulse the owner's done and go to IDLE.
  - A completion while still in ISSUE cannot occur, because returns lag issues.
- mem_data_valid in IDLE is ignored: no data_valid is asserted and no counter changes.
- Requests or addresses that change mid-fill are ignored until the fill returns to IDLE. The owner's grant stays high from ISSUE entry through the done cycle.
- Address arithmetic: base + 2*issue_cnt never carries out of the block, so there is no wrap-around concern. The 0xFFF0 block issues 0xFFF0..0xFFFE.
- Reset mid-fill:
  - All registers clear; state returns to IDLE.
  - Memory returns still in flight arrive while in IDLE and are dropped.
  - Both fill FSMs are reset by the same rst.
- Reset values: mem_en=0, mem_addr=0, all grant/data_valid/done outputs 0, owner=0, last_owner=0.

## Timing
- Request seen in IDLE at cycle T: grant and mem_en high at T+1 with mem_addr=base; last issue at T+8.
- With memory latency L: words return at T+1+L .. T+8+L. done pulses at T+8+L; grant is low and the state is IDLE at T+9+L.
- A request sampled in the IDLE cycle T+9+L issues at T+10+L. Back-to-back fills therefore have a one-cycle gap.
- data_valid, done and fill_data are combinational from mem_data_valid/mem_data; there is no added latency.

## Configuration
- CACHE_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests, the cache that did not win the last grant wins. last_owner updates at each grant.
- CACHE_ARB_RR_EN undefined: fixed priority, D-cache wins simultaneous requests. The last_owner register is not built.
- A lone request is granted immediately in both builds.

## Structure
- Shared cache package:
  - State encoding constants IDLE/ISSUE/DRAIN.
  - Owner encoding OWNER_I=0, OWNER_D=1.
  - BLOCK_BYTES=16 and WORD_BYTES=2, also used by the fill FSM.
- One sub-module, cache_arb_pick: the pure combinational owner select from the two requests and last_owner, with the round-robin/fixed choice under the macro.

## Test plan
- Single I-miss, icache_addr=0x1234, L=4: mem_addr 0x1230,0x1232..0x123E over 8 consecutive cycles. Eight icache_data_valid pulses with matching fill_data. icache_done at the 8th return. dcache outputs stay 0 throughout.
- Simultaneous I/D requests at 0x0040/0x8000: default build serves D first, then I after the one-cycle IDLE gap. With CACHE_ARB_RR_EN and last_owner=D, I is served first.
- D-request arrives mid I-fill: dcache_grant stays 0 until icache_done; D issue starts exactly 2 cycles after icache_done.
- Top block, dcache_addr=0xFFFF: last issued address is 0xFFFE; no wrap to 0x0000.
- Assert rst at the 3rd return: all outputs 0 the next cycle. The remaining 5 returns produce no data_valid. A fresh request then fills correctly from offset 0.
- Stray mem_data_valid in IDLE: no data_valid, no done, counters unchanged.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache fill path: arbiter state encoding,
// fill-owner encoding and block geometry used by the fill FSMs as well.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int BLOCK_BYTES = 16;
  localparam int WORD_BYTES  = 2;

endpackage

// File: rtl/cache_arb_pick.sv
// Owner select between the I-cache and D-cache fill requests.
// CACHE_ARB_RR_EN selects round-robin; otherwise the D-cache has fixed priority.
module cache_arb_pick
  import cache_mem_arbiter_pkg::*;
(
  input  logic icache_req,
  input  logic dcache_req,
`ifdef CACHE_ARB_RR_EN
  input  logic last_owner,
`endif
  output logic owner
);

  // Pick the fill owner; a lone request always wins
  always_comb begin
    owner = OWNER_D;
`ifdef CACHE_ARB_RR_EN
    if (icache_req && dcache_req) begin
      owner = ~last_owner;
    end else if (dcache_req) begin
      owner = OWNER_D;
    end else begin
      owner = OWNER_I;
    end
`else
    if (dcache_req) begin
      owner = OWNER_D;
    end else begin
      owner = OWNER_I;
    end
`endif
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I/D cache block fills onto the single pipelined memory read port,
// issuing one word address per cycle and steering returns to the fill owner.
// Optional macro CACHE_ARB_RR_EN enables round-robin arbitration.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_req,
  input  logic [ADDR_W-1:0] dcache_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              mem_data_valid,
  output logic [15:0]       fill_data,
  output logic              icache_data_valid,
  output logic              dcache_data_valid,
  output logic              icache_grant,
  output logic              dcache_grant,
  output logic              icache_done,
  output logic              dcache_done
);

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W = CNT_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  arb_state_t        state;
  logic              owner;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic              pick_owner;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] next_addr;
  logic              ret_ok;
  logic              last_ret;

`ifdef CACHE_ARB_RR_EN
  logic last_owner;

  cache_arb_pick u_pick (
    .icache_req (icache_req),
    .dcache_req (dcache_req),
    .last_owner (last_owner),
    .owner      (pick_owner)
  );
`else
  cache_arb_pick u_pick (
    .icache_req (icache_req),
    .dcache_req (dcache_req),
    .owner      (pick_owner)
  );
`endif

  assign req_addr  = (pick_owner == OWNER_D) ? dcache_addr : icache_addr;
  assign req_base  = req_addr & BASE_MASK;
  // Word offsets stay inside the block, so the add never carries past it
  assign next_addr = base + ADDR_W'({issue_cnt + CNT_W'(1), 1'b0});

  // Returns are only meaningful while a fill is in progress
  assign ret_ok            = (state != IDLE) && mem_data_valid;
  assign last_ret          = ret_ok && (ret_cnt == LAST_CNT);
  assign fill_data         = mem_data;
  assign icache_data_valid = ret_ok && (owner == OWNER_I);
  assign dcache_data_valid = ret_ok && (owner == OWNER_D);
  assign icache_done       = last_ret && (owner == OWNER_I);
  assign dcache_done       = last_ret && (owner == OWNER_D);

  // Fill sequencer: grant, address issue and return counting
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWNER_I;
      base         <= '0;
      issue_cnt    <= '0;
      ret_cnt      <= '0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      icache_grant <= 1'b0;
      dcache_grant <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      last_owner   <= OWNER_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (icache_req || dcache_req) begin
            state        <= ISSUE;
            owner        <= pick_owner;
            base         <= req_base;
            issue_cnt    <= '0;
            ret_cnt      <= '0;
            mem_en       <= 1'b1;
            mem_addr     <= req_base;
            icache_grant <= (pick_owner == OWNER_I);
            dcache_grant <= (pick_owner == OWNER_D);
`ifdef CACHE_ARB_RR_EN
            last_owner   <= pick_owner;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + CNT_W'(1);
          if (issue_cnt == LAST_CNT) begin
            state    <= DRAIN;
            mem_en   <= 1'b0;
            mem_addr <= '0;
          end else begin
            mem_addr <= next_addr;
          end
        end
        DRAIN: begin
          state <= DRAIN;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Returns lag issues, so the final return always lands in DRAIN
      if (ret_ok) begin
        ret_cnt <= ret_cnt + CNT_W'(1);
        if (ret_cnt == LAST_CNT) begin
          state        <= IDLE;
          mem_en       <= 1'b0;
          mem_addr     <= '0;
          icache_grant <= 1'b0;
          dcache_grant <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: fixed-latency memory model,
// time-based reference model checked every cycle, plus directed literal checks.
module tb_cache_mem_arbiter;

  localparam int LAT = 4;
  localparam int WPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_req = 1'b0;
  logic [15:0] icache_addr = 16'h0000;
  logic        dcache_req = 1'b0;
  logic [15:0] dcache_addr = 16'h0000;
  logic        stray_v = 1'b0;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic [15:0] fill_data;
  logic        icache_data_valid, dcache_data_valid;
  logic        icache_grant, dcache_grant;
  logic        icache_done, dcache_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // reference model state
  int          m_start = 0;
  bit          m_busy = 1'b0;
  bit          m_owner = 1'b0;
  logic [15:0] m_base = 16'h0000;
`ifdef CACHE_ARB_RR_EN
  bit          m_last = 1'b0;
`endif

  // observed statistics
  int n_ival = 0, n_dval = 0, n_idone = 0, n_ddone = 0;
  int igr_cyc = 0, dgr_cyc = 0;
  bit prev_igr = 1'b0, prev_dgr = 1'b0;
  logic [15:0] iss_q[$];

  // memory: pipelined read with fixed latency LAT cycles
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pa [LAT];

  cache_mem_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .icache_req        (icache_req),
    .icache_addr       (icache_addr),
    .dcache_req        (dcache_req),
    .dcache_addr       (dcache_addr),
    .mem_en            (mem_en),
    .mem_addr          (mem_addr),
    .mem_data          (mem_data),
    .mem_data_valid    (mem_data_valid),
    .fill_data         (fill_data),
    .icache_data_valid (icache_data_valid),
    .dcache_data_valid (dcache_data_valid),
    .icache_grant      (icache_grant),
    .dcache_grant      (dcache_grant),
    .icache_done       (icache_done),
    .dcache_done       (dcache_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], mem_en};
    pa[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
  end

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  assign mem_data_valid = pv[LAT-1] | stray_v;
  assign mem_data       = stray_v ? 16'hDEAD : word_of(pa[LAT-1]);

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a fill accepted in IDLE cycle T is active for T+1..T+WPB+LAT,
  // issues word j at T+1+j and returns it LAT cycles later.
  task automatic monitor();
    int k;
    bit act, e_iv, e_dv, e_done;
    forever begin
      @(negedge clk);
      k   = cyc - m_start;
      act = m_busy && (k >= 1);
      if (chk_en) begin
        e_iv   = mem_data_valid && act && !m_owner;
        e_dv   = mem_data_valid && act && m_owner;
        e_done = mem_data_valid && act && (k == WPB + LAT);
        chk1("icache_grant", icache_grant, act && !m_owner);
        chk1("dcache_grant", dcache_grant, act && m_owner);
        chk1("mem_en", mem_en, act && (k <= WPB));
        if (act && (k <= WPB)) chk16("mem_addr", mem_addr, m_base + 16'(2 * (k - 1)));
        chk1("icache_data_valid", icache_data_valid, e_iv);
        chk1("dcache_data_valid", dcache_data_valid, e_dv);
        chk1("icache_done", icache_done, e_done && !m_owner);
        chk1("dcache_done", dcache_done, e_done && m_owner);
        chk16("fill_data", fill_data, mem_data);
        if (e_iv || e_dv) chk16("fill_word", fill_data, word_of(m_base + 16'(2 * (k - 1 - LAT))));
        if (icache_data_valid) n_ival++;
        if (dcache_data_valid) n_dval++;
        if (icache_done) n_idone++;
        if (dcache_done) n_ddone++;
        if (icache_grant && !prev_igr) igr_cyc = cyc;
        if (dcache_grant && !prev_dgr) dgr_cyc = cyc;
        prev_igr = icache_grant;
        prev_dgr = dcache_grant;
        if (mem_en) iss_q.push_back(mem_addr);
      end
      if (rst) begin
        m_busy = 1'b0;
`ifdef CACHE_ARB_RR_EN
        m_last = 1'b0;
`endif
      end else if (m_busy && (k == WPB + LAT)) begin
        m_busy = 1'b0;
      end else if (!m_busy && (icache_req || dcache_req)) begin
`ifdef CACHE_ARB_RR_EN
        if (icache_req && dcache_req) m_owner = !m_last;
        else m_owner = dcache_req;
        m_last = m_owner;
`else
        m_owner = dcache_req;
`endif
        m_base  = (m_owner ? dcache_addr : icache_addr) & 16'hFFF0;
        m_start = cyc;
        m_busy  = 1'b1;
      end
    end
  endtask

  task automatic wait_done(input bit is_d, output int dc);
    bit seen;
    seen = 1'b0;
    dc   = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (is_d ? dcache_done : icache_done) begin
        seen = 1'b1;
        dc   = cyc;
      end
    end
    if (is_d) chk1("dcache_done seen", seen, 1'b1);
    else      chk1("icache_done seen", seen, 1'b1);
    @(posedge clk); #1;
    if (is_d) dcache_req = 1'b0;
    else      icache_req = 1'b0;
  endtask

  initial begin
    int t, dc, id, dd, sq, s_iv, s_dv, s_id, s_dd;
    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
      end
    join_none

    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1;
    chk1("reset icache_grant", icache_grant, 1'b0);
    chk1("reset dcache_grant", dcache_grant, 1'b0);
    chk1("reset mem_en", mem_en, 1'b0);
    chk16("reset mem_addr", mem_addr, 16'h0000);
    rst = 1'b0;

    // single I-miss
    s_iv = n_ival; s_dv = n_dval; s_dd = n_ddone; sq = iss_q.size();
    @(posedge clk); #1 icache_req = 1'b1; icache_addr = 16'h1234; t = cyc;
    wait_done(1'b0, dc);
    chki("A done latency", dc - t, 12);
    chki("A grant latency", igr_cyc - t, 1);
    chki("A i valids", n_ival - s_iv, 8);
    chki("A d valids", n_dval - s_dv, 0);
    chki("A d done", n_ddone - s_dd, 0);
    chki("A issued", iss_q.size() - sq, 8);
    chk16("A first addr", iss_q[sq], 16'h1230);
    chk16("A last addr", iss_q[sq + 7], 16'h123E);

    // simultaneous requests: D first, then I after one idle cycle
    sq = iss_q.size();
    @(posedge clk); #1;
    icache_req = 1'b1; icache_addr = 16'h0040;
    dcache_req = 1'b1; dcache_addr = 16'h8000; t = cyc;
    wait_done(1'b1, dd);
    chki("B d grant latency", dgr_cyc - t, 1);
    wait_done(1'b0, id);
    chki("B i grant gap", igr_cyc - dd, 2);
    chki("B i done", id - dd, 13);
    chk16("B d first addr", iss_q[sq], 16'h8000);
    chk16("B i first addr", iss_q[sq + 8], 16'h0040);

    // D request arriving mid I-fill waits for icache_done
    @(posedge clk); #1 icache_req = 1'b1; icache_addr = 16'h2000; t = cyc;
    repeat (3) @(posedge clk);
    #1 dcache_req = 1'b1; dcache_addr = 16'hABC0;
    wait_done(1'b0, id);
    wait_done(1'b1, dd);
    chki("C i done latency", id - t, 12);
    chki("C d grant after i done", dgr_cyc - id, 2);

    // top block, no wrap
    sq = iss_q.size();
    @(posedge clk); #1 dcache_req = 1'b1; dcache_addr = 16'hFFFF; t = cyc;
    wait_done(1'b1, dd);
    chki("D done latency", dd - t, 12);
    chk16("D first addr", iss_q[sq], 16'hFFF0);
    chk16("D last addr", iss_q[sq + 7], 16'hFFFE);

    // reset on the third return
    s_iv = n_ival;
    @(posedge clk); #1 icache_req = 1'b1; icache_addr = 16'h0100; t = cyc;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1; icache_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    chk1("E grant after rst", icache_grant, 1'b0);
    chk1("E mem_en after rst", mem_en, 1'b0);
    chk16("E mem_addr after rst", mem_addr, 16'h0000);
    repeat (10) @(posedge clk); #1;
    chki("E valids before reset", n_ival - s_iv, 3);
    s_iv = n_ival; sq = iss_q.size();
    @(posedge clk); #1 icache_req = 1'b1; icache_addr = 16'h0100; t = cyc;
    wait_done(1'b0, id);
    chki("E refill latency", id - t, 12);
    chki("E refill valids", n_ival - s_iv, 8);
    chk16("E refill first addr", iss_q[sq], 16'h0100);

    // stray return while idle
    s_iv = n_ival; s_dv = n_dval; s_id = n_idone; s_dd = n_ddone;
    @(posedge clk); #1 stray_v = 1'b1;
    @(posedge clk); #1 stray_v = 1'b0;
    @(posedge clk); #1;
    chki("F stray i valid", n_ival - s_iv, 0);
    chki("F stray d valid", n_dval - s_dv, 0);
    chki("F stray dones", (n_idone - s_id) + (n_ddone - s_dd), 0);
    s_dv = n_dval;
    @(posedge clk); #1 dcache_req = 1'b1; dcache_addr = 16'h0400; t = cyc;
    wait_done(1'b1, dd);
    chki("F fill after stray latency", dd - t, 12);
    chki("F fill after stray valids", n_dval - s_dv, 8);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
